control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and serve as the single clock; all state updates occur on its rising edge.
REQ-002 The port reset SHALL be an input, 1 bit wide, asynchronous and active-low (0 = reset).
REQ-003 The port instruction SHALL be an input, 16 bits wide, carrying the instruction word from memory; it is valid while memReady=1 in FETCH.
REQ-004 The port memReady SHALL be an input, 1 bit wide, and acknowledge the current memRead or memWrite in that cycle.
REQ-005 The port condTrue SHALL be an input, 1 bit wide: the condition-check result for the latched condition field, from the flag unit.
REQ-006 The port instructionOp SHALL be an output, 8 bits wide, equal to the latched {instruction[15:12], instruction[7:4]} and driven to the sign-extend unit.
REQ-007 The ports irLoad, pcWrite, memRead, memWrite, regWrite, flagWrite, aluSrcImm, illegalOp and busError SHALL each be 1-bit outputs.
REQ-008 The ports pcSrc and wbSel SHALL each be 2-bit outputs: pcSrc 0=PC+1, 1=PC+displacement, 2=register target; wbSel 0=ALU, 1=memory.
REQ-009 The port state SHALL be an output, 3 bits wide, exposing the current FSM state for debug.

Function
REQ-010 The FSM SHALL have the states FETCH, DECODE, EXECUTE, MEM, BRANCH and WRITEBACK, with all outputs decoded from the registered state and latched opcode (Moore outputs).
REQ-011 In FETCH, the block SHALL hold memRead=1; on memReady=1 it pulses irLoad for one cycle, latches instructionOp and moves to DECODE.
REQ-012 DECODE SHALL last exactly one cycle and classify the opcode by its top byte:
- 0x0? → R-type
- 0x50/0x90/0xB0/0xE0/0x10 → I-type
- 0x80/0x81 → LSHI
- 0x40 → LOAD
- 0x44 → STOR
- 0xC? → BCOND
- 0x4C → JCOND
- anything else → illegal
REQ-013 R-type, I-type and LSHI SHALL take the path DECODE→EXECUTE→WRITEBACK; aluSrcImm=1 in EXECUTE and WRITEBACK for I-type and LSHI only.
REQ-014 flagWrite SHALL pulse in EXECUTE for ADD(0x05), SUB(0x09), CMP(0x0B), ADDI, SUBI and CMPI.
REQ-015 CMP and CMPI SHALL NOT assert regWrite in WRITEBACK.
REQ-016 LOAD SHALL go DECODE→MEM, holding memRead=1 until memReady, then WRITEBACK with regWrite=1 and wbSel=1.
REQ-017 STOR SHALL go DECODE→MEM, holding memWrite=1 until memReady, then WRITEBACK with regWrite=0.
REQ-018 WRITEBACK SHALL last one cycle, assert pcWrite=1 with pcSrc=0, and return to FETCH.
REQ-019 BCOND and JCOND SHALL go DECODE→BRANCH, where pcWrite=1 and pcSrc is 1 (BCOND) or 2 (JCOND) if condTrue=1, else 0; BRANCH then returns to FETCH.
REQ-020 An illegal opcode SHALL pulse illegalOp in DECODE, then go to WRITEBACK with regWrite=0, so the PC advances and no architectural state changes.
REQ-021 An 8-bit wait counter SHALL clear on entry to FETCH or MEM and increment each cycle that memReady=0 in those states.
REQ-022 When the wait counter reaches 255 with memReady still 0, the block SHALL pulse busError for one cycle, drop memRead/memWrite and go to FETCH without pcWrite, retrying the same PC.
REQ-023 If memReady=1 in the same cycle the counter reaches 255, the access SHALL complete normally with no busError.
REQ-024 Best-case latency SHALL be 4 cycles for ALU ops, 4 for LOAD/STOR and 3 for branches (FETCH to FETCH, with memReady=1 on first request).
REQ-025 memRead and memWrite SHALL never be asserted simultaneously.
REQ-026 At most one of irLoad and pcWrite SHALL be high in any cycle.

Reset
REQ-027 While reset=0, the block SHALL enter FETCH, set instructionOp=0x00, clear the wait counter and drive all 1-bit outputs, pcSrc and wbSel to 0.
REQ-028 A reset asserted mid-access SHALL abandon the access immediately without completing any regWrite, memWrite or pcWrite.
REQ-029 The first memRead SHALL appear in the first cycle after reset deasserts.

Structure
REQ-030 A shared package SHALL hold the opcode constants (ADDI 0x50, MULI 0xE0, SUBI 0x90, CMPI 0xB0, ANDI 0x10, LSHI0 0x80, LSHI1 0x81, BCOND 0xC0, LOAD 0x40, STOR 0x44, JCOND 0x4C), the state encoding and the pcSrc/wbSel encodings.
REQ-031 Opcode classification SHALL live in one combinational sub-module, op_class_decode, instantiated once.

Verification
REQ-032 ADDI 0x5003 with memReady always 1 → FETCH,DECODE,EXECUTE,WRITEBACK; flagWrite in EXECUTE; regWrite=1, aluSrcImm=1 and pcWrite=1 in WRITEBACK.
REQ-033 LOAD with memReady low for 3 MEM cycles → memRead held 4 cycles; then WRITEBACK with wbSel=1 and regWrite=1.
REQ-034 BCOND instruction 0xC0FE with condTrue=1, then 0 → pcSrc=1 then 0 in BRANCH; pcWrite=1 both times; no regWrite.
REQ-035 memReady held 0 in FETCH → busError pulse in the 256th wait cycle; return to FETCH; pcWrite never asserted.
REQ-036 Opcode byte 0x3F → illegalOp pulse in DECODE; WRITEBACK with regWrite=0 and pcWrite=1.
REQ-037 reset driven 0 during MEM of a STOR → memWrite drops the same cycle; state=FETCH and all outputs 0 until release.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared constants for the control sequencer: opcode bytes, FSM state codes,
// PC/writeback source selects and the opcode classification types.
package control_sequencer_pkg;

    localparam logic [7:0] OP_ADD   = 8'h05;
    localparam logic [7:0] OP_SUB   = 8'h09;
    localparam logic [7:0] OP_CMP   = 8'h0B;
    localparam logic [7:0] OP_ADDI  = 8'h50;
    localparam logic [7:0] OP_MULI  = 8'hE0;
    localparam logic [7:0] OP_SUBI  = 8'h90;
    localparam logic [7:0] OP_CMPI  = 8'hB0;
    localparam logic [7:0] OP_ANDI  = 8'h10;
    localparam logic [7:0] OP_LSHI0 = 8'h80;
    localparam logic [7:0] OP_LSHI1 = 8'h81;
    localparam logic [7:0] OP_BCOND = 8'hC0;
    localparam logic [7:0] OP_LOAD  = 8'h40;
    localparam logic [7:0] OP_STOR  = 8'h44;
    localparam logic [7:0] OP_JCOND = 8'h4C;

    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_EXECUTE   = 3'd2;
    localparam logic [2:0] ST_MEM       = 3'd3;
    localparam logic [2:0] ST_BRANCH    = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;

    localparam logic [1:0] PC_SRC_INC  = 2'd0;
    localparam logic [1:0] PC_SRC_DISP = 2'd1;
    localparam logic [1:0] PC_SRC_REG  = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;

    localparam logic [7:0] WAIT_LIMIT = 8'hFF;

    typedef enum logic [2:0] {
        CLASS_RTYPE,
        CLASS_ITYPE,
        CLASS_LSHI,
        CLASS_LOAD,
        CLASS_STOR,
        CLASS_BCOND,
        CLASS_JCOND,
        CLASS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        op_class_t op_class;
        logic      sets_flags;
        logic      writes_reg;
    } op_info_t;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier: maps the latched opcode byte to its
// instruction class plus the flag-update and register-write attributes.
module op_class_decode
    import control_sequencer_pkg::*;
(
    input  logic [7:0] op,
    output op_info_t   info
);

    always_comb begin
        info.op_class   = CLASS_ILLEGAL;
        info.sets_flags = 1'b0;
        info.writes_reg = 1'b0;

        if (op[7:4] == 4'h0) begin
            info.op_class = CLASS_RTYPE;
        end else if (op[7:4] == 4'hC) begin
            info.op_class = CLASS_BCOND;
        end else begin
            case (op)
                OP_ADDI, OP_SUBI, OP_CMPI, OP_MULI, OP_ANDI: info.op_class = CLASS_ITYPE;
                OP_LSHI0, OP_LSHI1:                          info.op_class = CLASS_LSHI;
                OP_LOAD:                                     info.op_class = CLASS_LOAD;
                OP_STOR:                                     info.op_class = CLASS_STOR;
                OP_JCOND:                                    info.op_class = CLASS_JCOND;
                default:                                     info.op_class = CLASS_ILLEGAL;
            endcase
        end

        info.sets_flags = (op == OP_ADD)  || (op == OP_SUB)  || (op == OP_CMP) ||
                          (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);

        // Compares only update flags, so they never write the register file.
        case (info.op_class)
            CLASS_RTYPE, CLASS_ITYPE, CLASS_LSHI:
                info.writes_reg = (op != OP_CMP) && (op != OP_CMPI);
            CLASS_LOAD:
                info.writes_reg = 1'b1;
            default:
                info.writes_reg = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches an instruction, classifies it and
// steps through execute/memory/branch/writeback with a memory wait timeout.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        memReady,
    input  logic        condTrue,
    output logic [7:0]  instructionOp,
    output logic        irLoad,
    output logic        pcWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        regWrite,
    output logic        flagWrite,
    output logic        aluSrcImm,
    output logic        illegalOp,
    output logic        busError,
    output logic [1:0]  pcSrc,
    output logic [1:0]  wbSel,
    output logic [2:0]  state
);

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [7:0] op_q;
    logic [7:0] wait_cnt;
    logic       retry_gap;
    logic       access;
    logic       fetch_accept;
    logic       timeout;
    logic       is_load;
    logic       is_stor;
    logic       is_imm;
    logic       unused_instr_bits;
    op_info_t   info;

    op_class_decode u_op_class_decode (
        .op   (op_q),
        .info (info)
    );

    assign unused_instr_bits = ^{instruction[11:8], instruction[3:0]};

    // After a timeout, FETCH spends one cycle with no request so the memory
    // sees the retried read as a fresh access.
    assign access       = ((state_q == ST_FETCH) && !retry_gap) || (state_q == ST_MEM);
    assign fetch_accept = (state_q == ST_FETCH) && !retry_gap && memReady;
    assign timeout      = access && !memReady && (wait_cnt == WAIT_LIMIT);

    assign is_load = (info.op_class == CLASS_LOAD);
    assign is_stor = (info.op_class == CLASS_STOR);
    assign is_imm  = (info.op_class == CLASS_ITYPE) || (info.op_class == CLASS_LSHI);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (fetch_accept) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (info.op_class)
                    CLASS_RTYPE, CLASS_ITYPE, CLASS_LSHI: state_d = ST_EXECUTE;
                    CLASS_LOAD, CLASS_STOR:               state_d = ST_MEM;
                    CLASS_BCOND, CLASS_JCOND:             state_d = ST_BRANCH;
                    default:                              state_d = ST_WRITEBACK;
                endcase
            end
            ST_EXECUTE: state_d = ST_WRITEBACK;
            ST_MEM: begin
                if (memReady) begin
                    state_d = ST_WRITEBACK;
                end else if (timeout) begin
                    state_d = ST_FETCH;
                end
            end
            ST_BRANCH:    state_d = ST_FETCH;
            ST_WRITEBACK: state_d = ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            op_q      <= 8'h00;
            wait_cnt  <= 8'h00;
            retry_gap <= 1'b0;
        end else begin
            state_q   <= state_d;
            retry_gap <= timeout;
            if (fetch_accept) begin
                op_q <= {instruction[15:12], instruction[7:4]};
            end
            // Any state change (or a timeout retry) starts a fresh wait count.
            if (timeout || (state_d != state_q)) begin
                wait_cnt <= 8'h00;
            end else if (access && !memReady) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    assign instructionOp = op_q;
    assign state         = state_q;

    always_comb begin
        irLoad    = 1'b0;
        pcWrite   = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        regWrite  = 1'b0;
        flagWrite = 1'b0;
        aluSrcImm = 1'b0;
        illegalOp = 1'b0;
        busError  = 1'b0;
        pcSrc     = PC_SRC_INC;
        wbSel     = WB_SEL_ALU;

        // Outputs are gated by reset so an abandoned access drops immediately.
        if (reset) begin
            busError = timeout;
            case (state_q)
                ST_FETCH: begin
                    memRead = !retry_gap;
                    irLoad  = fetch_accept;
                end
                ST_DECODE: begin
                    illegalOp = (info.op_class == CLASS_ILLEGAL);
                end
                ST_EXECUTE: begin
                    flagWrite = info.sets_flags;
                    aluSrcImm = is_imm;
                end
                ST_MEM: begin
                    memRead  = is_load;
                    memWrite = is_stor;
                end
                ST_BRANCH: begin
                    pcWrite = 1'b1;
                    if (condTrue) begin
                        pcSrc = (info.op_class == CLASS_BCOND) ? PC_SRC_DISP : PC_SRC_REG;
                    end
                end
                ST_WRITEBACK: begin
                    pcWrite   = 1'b1;
                    regWrite  = info.writes_reg;
                    aluSrcImm = is_imm;
                    wbSel     = is_load ? WB_SEL_MEM : WB_SEL_ALU;
                end
                default: begin
                    pcWrite = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed scoreboard bench for control_sequencer: each step drives inputs,
// queues the expected outputs for that cycle, then pops and compares them.
module tb_control_sequencer;

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEM       = 3'd3;
    localparam logic [2:0] S_BRANCH    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;

    typedef struct packed {
        logic [2:0] st;
        logic       irLoad;
        logic       pcWrite;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic       flagWrite;
        logic       aluSrcImm;
        logic       illegalOp;
        logic       busError;
        logic [1:0] pcSrc;
        logic [1:0] wbSel;
    } outVec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic        memReady;
    logic        condTrue;
    logic [7:0]  instructionOp;
    logic        irLoad, pcWrite, memRead, memWrite, regWrite;
    logic        flagWrite, aluSrcImm, illegalOp, busError;
    logic [1:0]  pcSrc, wbSel;
    logic [2:0]  state;

    int testsRun  = 0;
    int failCount = 0;
    outVec_t expQ[$];
    string   tagQ[$];

    control_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .instruction   (instruction),
        .memReady      (memReady),
        .condTrue      (condTrue),
        .instructionOp (instructionOp),
        .irLoad        (irLoad),
        .pcWrite       (pcWrite),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .regWrite      (regWrite),
        .flagWrite     (flagWrite),
        .aluSrcImm     (aluSrcImm),
        .illegalOp     (illegalOp),
        .busError      (busError),
        .pcSrc         (pcSrc),
        .wbSel         (wbSel),
        .state         (state)
    );

    always #5 clk = ~clk;

    function automatic outVec_t mkOut(input logic [2:0] st, input logic irl, input logic pcw,
                                      input logic mr, input logic mw, input logic rw,
                                      input logic fw, input logic ai, input logic il,
                                      input logic be, input logic [1:0] ps, input logic [1:0] ws);
        outVec_t v;
        v = {st, irl, pcw, mr, mw, rw, fw, ai, il, be, ps, ws};
        return v;
    endfunction

    function automatic outVec_t idle(input logic [2:0] st);
        return mkOut(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    endfunction

    function automatic outVec_t fetchOut(input logic irl, input logic be);
        return mkOut(S_FETCH, irl, 0, 1, 0, 0, 0, 0, 0, be, 2'd0, 2'd0);
    endfunction

    function automatic outVec_t observed();
        outVec_t v;
        v = {state, irLoad, pcWrite, memRead, memWrite, regWrite, flagWrite,
             aluSrcImm, illegalOp, busError, pcSrc, wbSel};
        return v;
    endfunction

    task automatic applyStimulus(input logic rstVal, input logic [15:0] instr, input logic ready,
                                 input logic cond, input outVec_t expVec, input string tag);
        @(negedge clk);
        reset       = rstVal;
        instruction = instr;
        memReady    = ready;
        condTrue    = cond;
        expQ.push_back(expVec);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput();
        outVec_t expVec;
        outVec_t obsVec;
        string   tag;
        #1;
        expVec = expQ.pop_front();
        tag    = tagQ.pop_front();
        obsVec = observed();
        testsRun++;
        assert (obsVec === expVec) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b required %b (st|irl pcw mr mw rw fw ai il be|ps|ws)",
                   tag, obsVec, expVec);
        end
    endtask

    task automatic step(input logic rstVal, input logic [15:0] instr, input logic ready,
                        input logic cond, input outVec_t expVec, input string tag);
        applyStimulus(rstVal, instr, ready, cond, expVec, tag);
        checkOutput();
    endtask

    task automatic checkOp(input string tag, input logic [7:0] expOp);
        testsRun++;
        assert (instructionOp === expOp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed instructionOp %h required %h", tag, instructionOp, expOp);
        end
    endtask

    initial begin
        reset       = 1'b0;
        instruction = 16'h0000;
        memReady    = 1'b0;
        condTrue    = 1'b0;

        // Reset holds FETCH with every output low, even with memReady high.
        step(0, 16'h5003, 1, 1, idle(S_FETCH), "reset_hold0");
        step(0, 16'h5003, 1, 1, idle(S_FETCH), "reset_hold1");
        checkOp("reset_op", 8'h00);

        // ADDI 0x5003, memReady always high.
        step(1, 16'h5003, 1, 0, fetchOut(1, 0), "addi_fetch");
        step(1, 16'h5003, 1, 0, idle(S_DECODE), "addi_decode");
        checkOp("addi_op", 8'h50);
        step(1, 16'h5003, 1, 0, mkOut(S_EXECUTE, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 2'd0), "addi_exec");
        step(1, 16'h5003, 1, 0, mkOut(S_WRITEBACK, 0, 1, 0, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0), "addi_wb");

        // LOAD with three wait cycles in MEM.
        step(1, 16'h4000, 1, 0, fetchOut(1, 0), "load_fetch");
        step(1, 16'h4000, 1, 0, idle(S_DECODE), "load_decode");
        checkOp("load_op", 8'h40);
        for (int i = 0; i < 3; i++)
            step(1, 16'h4000, 0, 0, mkOut(S_MEM, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0), "load_mem_wait");
        step(1, 16'h4000, 1, 0, mkOut(S_MEM, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0), "load_mem_ready");
        step(1, 16'h4000, 1, 0, mkOut(S_WRITEBACK, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd1), "load_wb");

        // BCOND taken, then not taken.
        step(1, 16'hC0FE, 1, 1, fetchOut(1, 0), "bcond_fetch");
        step(1, 16'hC0FE, 1, 1, idle(S_DECODE), "bcond_decode");
        checkOp("bcond_op", 8'hCF);
        step(1, 16'hC0FE, 1, 1, mkOut(S_BRANCH, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0), "bcond_taken");
        step(1, 16'hC0FE, 1, 0, fetchOut(1, 0), "bcond2_fetch");
        step(1, 16'hC0FE, 1, 0, idle(S_DECODE), "bcond2_decode");
        step(1, 16'hC0FE, 1, 0, mkOut(S_BRANCH, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0), "bcond_not_taken");

        // JCOND taken selects the register target.
        step(1, 16'h40C0, 1, 1, fetchOut(1, 0), "jcond_fetch");
        step(1, 16'h40C0, 1, 1, idle(S_DECODE), "jcond_decode");
        step(1, 16'h40C0, 1, 1, mkOut(S_BRANCH, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0), "jcond_taken");

        // CMP sets flags but does not write a register.
        step(1, 16'h00B0, 1, 0, fetchOut(1, 0), "cmp_fetch");
        step(1, 16'h00B0, 1, 0, idle(S_DECODE), "cmp_decode");
        step(1, 16'h00B0, 1, 0, mkOut(S_EXECUTE, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0), "cmp_exec");
        step(1, 16'h00B0, 1, 0, mkOut(S_WRITEBACK, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0), "cmp_wb");

        // LSHI (0x81): immediate operand, no flag update.
        step(1, 16'h8010, 1, 0, fetchOut(1, 0), "lshi_fetch");
        step(1, 16'h8010, 1, 0, idle(S_DECODE), "lshi_decode");
        step(1, 16'h8010, 1, 0, mkOut(S_EXECUTE, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0), "lshi_exec");
        step(1, 16'h8010, 1, 0, mkOut(S_WRITEBACK, 0, 1, 0, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0), "lshi_wb");

        // STOR with immediate ready.
        step(1, 16'h4040, 1, 0, fetchOut(1, 0), "stor_fetch");
        step(1, 16'h4040, 1, 0, idle(S_DECODE), "stor_decode");
        step(1, 16'h4040, 1, 0, mkOut(S_MEM, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0), "stor_mem");
        step(1, 16'h4040, 1, 0, mkOut(S_WRITEBACK, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0), "stor_wb");

        // Illegal opcode byte 0x3F.
        step(1, 16'h30F0, 1, 0, fetchOut(1, 0), "illegal_fetch");
        step(1, 16'h30F0, 1, 0, mkOut(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0), "illegal_decode");
        checkOp("illegal_op", 8'h3F);
        step(1, 16'h30F0, 1, 0, mkOut(S_WRITEBACK, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0), "illegal_wb");

        // Bus timeout in FETCH: 255 quiet waits, error on the 256th, then a request-free retry gap.
        for (int i = 0; i < 255; i++)
            step(1, 16'h0050, 0, 0, fetchOut(0, 0), "bus_wait");
        step(1, 16'h0050, 0, 0, fetchOut(0, 1), "bus_error");
        step(1, 16'h0050, 0, 0, idle(S_FETCH), "bus_retry_gap");

        // memReady arriving exactly at the limit completes without an error.
        for (int i = 0; i < 255; i++)
            step(1, 16'h0050, 0, 0, fetchOut(0, 0), "limit_wait");
        step(1, 16'h0050, 1, 0, fetchOut(1, 0), "ready_at_limit");
        step(1, 16'h0050, 1, 0, idle(S_DECODE), "add_decode");
        checkOp("add_op", 8'h05);
        step(1, 16'h0050, 1, 0, mkOut(S_EXECUTE, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0), "add_exec");
        step(1, 16'h0050, 1, 0, mkOut(S_WRITEBACK, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0), "add_wb");

        // Reset asserted while a STOR waits in MEM.
        step(1, 16'h4040, 1, 0, fetchOut(1, 0), "rst_stor_fetch");
        step(1, 16'h4040, 1, 0, idle(S_DECODE), "rst_stor_decode");
        step(1, 16'h4040, 0, 0, mkOut(S_MEM, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0), "rst_stor_mem");
        step(0, 16'h4040, 1, 0, idle(S_FETCH), "rst_mid_access");
        step(0, 16'h4040, 1, 0, idle(S_FETCH), "rst_mid_hold");
        checkOp("rst_mid_op", 8'h00);
        step(1, 16'h4040, 0, 0, fetchOut(0, 0), "rst_release_fetch");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
